// File: rtl/rx_adc_ti_pkg.sv
// Shared helpers for the time-interleaved RX ADC emulation core.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package rx_adc_ti_pkg;

    // Index width for n entries, never narrower than one bit.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r == 0) ? 1 : r;
    endfunction

    function automatic real pow2(input int e);
        real r;
        r = 1.0;
        if (e >= 0) begin
            for (int i = 0; i < e; i++) r = r * 2.0;
        end else begin
            for (int i = 0; i < -e; i++) r = r / 2.0;
        end
        return r;
    endfunction

    // Round to nearest, ties away from zero.
    function automatic int round_real(input real x);
        if (x >= 0.0) return $rtoi(x + 0.5);
        else          return -$rtoi(-x + 0.5);
    endfunction

    // Input-domain code of the mid-scale voltage.
    function automatic int calc_mid(input real v_p, input real v_n, input int in_exp);
        return round_real(((v_p + v_n) / 2.0) / pow2(in_exp));
    endfunction

    // Fixed-point gain from input LSBs to output LSBs, gain_frac fractional bits.
    function automatic int calc_gain(input real v_p, input real v_n, input int n_adc,
                                     input int in_exp, input int gain_frac);
        return round_real(pow2(n_adc) / (v_p - v_n) * pow2(in_exp) * pow2(gain_frac));
    endfunction

    // Clip v into the signed n-bit range.
    function automatic logic signed [63:0] saturate(input logic signed [63:0] v, input int n);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (n - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (n - 1));
        if (v > hi)      return hi;
        else if (v < lo) return lo;
        else             return v;
    endfunction

endpackage

// File: rtl/rx_adc_ti_core_if.sv
// Sample-in / frame-out bundle of the interleaved ADC core.
// Latency: n/a (wiring only).
// Backpressure: none; the frame side is a valid-only pulse.
// master drives the analog sample side, slave is the core.
interface rx_adc_ti_core_if
    import rx_adc_ti_pkg::*;
#(
    parameter int N_CH     = 16,
    parameter int N_ADC    = 8,
    parameter int IN_WIDTH = 18
) ();
    localparam int CH_W = clog2(N_CH);

    logic signed [IN_WIDTH-1:0] in_;
    logic                       in_valid;
    logic                       clk_val;
    logic                       align;
    logic [N_CH*N_ADC-1:0]      out;
    logic                       out_valid;
    logic                       out_invalid;
    logic [CH_W-1:0]            ch_ptr;

    modport master (
        output in_, in_valid, clk_val, align,
        input  out, out_valid, out_invalid, ch_ptr
    );

    modport slave (
        input  in_, in_valid, clk_val, align,
        output out, out_valid, out_invalid, ch_ptr
    );
endinterface

// File: rtl/rx_adc_quant.sv
// Quantiser: (in - MID) * GAIN, round-half-up, add offset, clip to N_ADC bits.
// Latency: 1 cycle to the stage-1 register; stage-2 result is combinational from it.
// Backpressure: none; accepts one sample per cycle, never stalls.
// Ports: in_* carry the sample, its channel, in_valid flag and channel offset;
// out_* return the code with its channel/flag, out_sat marks a clipped valid sample.
module rx_adc_quant
    import rx_adc_ti_pkg::*;
#(
    parameter int IN_WIDTH  = 18,
    parameter int N_ADC     = 8,
    parameter int CH_W      = 4,
    parameter int GAIN_FRAC = 14,
    parameter int MID       = 0,
    parameter int GAIN      = 512
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_vld,
    input  logic signed [IN_WIDTH-1:0] in_dat,
    input  logic                       in_ok,
    input  logic [CH_W-1:0]            in_ch,
    input  logic signed [N_ADC-1:0]    in_off,
    output logic                       out_vld,
    output logic [CH_W-1:0]            out_ch,
    output logic signed [N_ADC-1:0]    out_dat,
    output logic                       out_ok,
    output logic                       out_sat
);
    // Full-precision product: one guard bit for the MID subtraction plus a 32-bit gain.
    localparam int PROD_W = IN_WIDTH + 1 + 32;
    localparam logic signed [63:0] RND = 64'sd1 <<< (GAIN_FRAC - 1);

    logic                       s1_vld_q, s1_vld_d;
    logic                       s1_ok_q,  s1_ok_d;
    logic [CH_W-1:0]            s1_ch_q,  s1_ch_d;
    logic signed [N_ADC-1:0]    s1_off_q, s1_off_d;
    logic signed [PROD_W-1:0]   prod_q,   prod_d;

    logic signed [IN_WIDTH:0]   diff;
    logic signed [63:0]         rounded;
    logic signed [63:0]         summed;
    logic signed [63:0]         clipped;

    // Stage 1: multiply; sideband is captured only with a sample.
    always_comb begin
        diff     = (IN_WIDTH+1)'(in_dat) - (IN_WIDTH+1)'(MID);
        s1_vld_d = in_vld;
        s1_ok_d  = in_vld ? in_ok  : s1_ok_q;
        s1_ch_d  = in_vld ? in_ch  : s1_ch_q;
        s1_off_d = in_vld ? in_off : s1_off_q;
        prod_d   = in_vld ? PROD_W'(diff) * PROD_W'(GAIN) : prod_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q <= 1'b0;
            s1_ok_q  <= 1'b0;
            s1_ch_q  <= '0;
            s1_off_q <= '0;
            prod_q   <= '0;
        end else begin
            s1_vld_q <= s1_vld_d;
            s1_ok_q  <= s1_ok_d;
            s1_ch_q  <= s1_ch_d;
            s1_off_q <= s1_off_d;
            prod_q   <= prod_d;
        end
    end

    // Stage 2: rounding and offset are done wide so only one clip is needed.
    always_comb begin
        rounded = (64'(prod_q) + RND) >>> GAIN_FRAC;
        summed  = rounded + 64'(s1_off_q);
        clipped = saturate(summed, N_ADC);
        out_vld = s1_vld_q;
        out_ch  = s1_ch_q;
        out_ok  = s1_ok_q;
        // A sample taken with in_valid low is stored as zero and never counts as clipped.
        out_dat = s1_ok_q ? clipped[N_ADC-1:0] : '0;
        out_sat = s1_vld_q & s1_ok_q & (clipped != summed);
    end

endmodule

// File: rtl/rx_adc_ti_core.sv
// Time-interleaved RX ADC emulation: round-robin samples into N_CH channels, double-buffered frame.
// Latency: sampling edge in cycle 0 -> shadow write end of cycle 1 -> out/out_valid in cycle 2.
// Backpressure: none; events need >= 2 cycles spacing by construction, pipeline never stalls.
// Ports: emu_clk/emu_rst_n; io = sample inputs, align, frame outputs and ch_ptr;
// cfg_* program per-channel offsets; sat_clr clears sat_cnt; dt_req mirrors dt_req_max.
module rx_adc_ti_core
    import rx_adc_ti_pkg::*;
#(
    parameter int  N_CH      = 16,
    parameter int  N_ADC     = 8,
    parameter int  IN_WIDTH  = 18,
    parameter int  IN_EXP    = -12,
    parameter real V_REF_P   = 1.0,
    parameter real V_REF_N   = -1.0,
    parameter int  GAIN_FRAC = 14,
    parameter int  DT_WIDTH  = 27,
    parameter int  SAT_CNT_W = 16,
    localparam int CH_W      = clog2(N_CH)
) (
    input  logic                     emu_clk,
    input  logic                     emu_rst_n,
    rx_adc_ti_core_if.slave          io,
    input  logic                     cfg_we,
    input  logic [CH_W-1:0]          cfg_addr,
    input  logic signed [N_ADC-1:0]  cfg_data,
    input  logic                     sat_clr,
    input  logic [DT_WIDTH-1:0]      dt_req_max,
    output logic [DT_WIDTH-1:0]      dt_req,
    output logic [SAT_CNT_W-1:0]     sat_cnt,
    input  logic [DT_WIDTH-1:0]      emu_dt
);
    localparam int              MID     = calc_mid(V_REF_P, V_REF_N, IN_EXP);
    localparam int              GAIN    = calc_gain(V_REF_P, V_REF_N, N_ADC, IN_EXP, GAIN_FRAC);
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(N_CH - 1);

    logic                            clk_prev_q,    clk_prev_d;
    logic [CH_W-1:0]                 ch_ptr_q,      ch_ptr_d;
    logic [N_CH-1:0][N_ADC-1:0]      offset_q,      offset_d;
    logic [N_CH-1:0][N_ADC-1:0]      shadow_q,      shadow_d;
    logic                            frame_bad_q,   frame_bad_d;
    logic [N_CH-1:0][N_ADC-1:0]      out_q,         out_d;
    logic                            out_valid_q,   out_valid_d;
    logic                            out_invalid_q, out_invalid_d;
    logic [SAT_CNT_W-1:0]            sat_cnt_q,     sat_cnt_d;

    logic                            sample_evt;
    logic [CH_W-1:0]                 samp_ch;
    logic                            q_vld;
    logic [CH_W-1:0]                 q_ch;
    logic signed [N_ADC-1:0]         q_code;
    logic                            q_ok;
    logic                            q_sat;

    // The granted timestep has no influence on this model.
    logic unused_emu_dt;
    assign unused_emu_dt = ^emu_dt;

    assign dt_req = dt_req_max;

    // An align in the sampling cycle steers that sample to channel 0.
    assign sample_evt = io.clk_val & ~clk_prev_q;
    assign samp_ch    = io.align ? '0 : ch_ptr_q;

    rx_adc_quant #(
        .IN_WIDTH  (IN_WIDTH),
        .N_ADC     (N_ADC),
        .CH_W      (CH_W),
        .GAIN_FRAC (GAIN_FRAC),
        .MID       (MID),
        .GAIN      (GAIN)
    ) u_quant (
        .clk     (emu_clk),
        .rst_n   (emu_rst_n),
        .in_vld  (sample_evt),
        .in_dat  (io.in_),
        .in_ok   (io.in_valid),
        .in_ch   (samp_ch),
        .in_off  (signed'(offset_q[samp_ch])),
        .out_vld (q_vld),
        .out_ch  (q_ch),
        .out_dat (q_code),
        .out_ok  (q_ok),
        .out_sat (q_sat)
    );

    always_comb begin
        clk_prev_d    = io.clk_val;
        ch_ptr_d      = ch_ptr_q;
        offset_d      = offset_q;
        shadow_d      = shadow_q;
        frame_bad_d   = frame_bad_q;
        out_d         = out_q;
        out_valid_d   = 1'b0;
        out_invalid_d = out_invalid_q;
        sat_cnt_d     = sat_cnt_q;

        if (sample_evt) begin
            ch_ptr_d = (samp_ch == LAST_CH) ? '0 : samp_ch + CH_W'(1);
        end else if (io.align) begin
            ch_ptr_d = '0;
        end

        // Offsets update after this cycle's sample has already captured the old value.
        if (cfg_we) begin
            offset_d[cfg_addr] = cfg_data;
        end

        // Align drops the partial frame first; an in-flight sample still lands afterwards.
        if (io.align) begin
            shadow_d    = '0;
            frame_bad_d = 1'b0;
        end

        if (q_vld) begin
            shadow_d[q_ch] = q_code;
            if (!q_ok) begin
                frame_bad_d = 1'b1;
            end
            if (q_ch == LAST_CH) begin
                out_d         = shadow_d;
                out_valid_d   = 1'b1;
                out_invalid_d = frame_bad_d;
                frame_bad_d   = 1'b0;
            end
        end

        // Clear wins over the old count but not over a clip in the same cycle.
        if (sat_clr) begin
            sat_cnt_d = q_sat ? SAT_CNT_W'(1) : '0;
        end else if (q_sat && (sat_cnt_q != '1)) begin
            sat_cnt_d = sat_cnt_q + SAT_CNT_W'(1);
        end
    end

    always_ff @(posedge emu_clk or negedge emu_rst_n) begin
        if (!emu_rst_n) begin
            clk_prev_q    <= 1'b0;
            ch_ptr_q      <= '0;
            offset_q      <= '0;
            shadow_q      <= '0;
            frame_bad_q   <= 1'b0;
            out_q         <= '0;
            out_valid_q   <= 1'b0;
            out_invalid_q <= 1'b0;
            sat_cnt_q     <= '0;
        end else begin
            clk_prev_q    <= clk_prev_d;
            ch_ptr_q      <= ch_ptr_d;
            offset_q      <= offset_d;
            shadow_q      <= shadow_d;
            frame_bad_q   <= frame_bad_d;
            out_q         <= out_d;
            out_valid_q   <= out_valid_d;
            out_invalid_q <= out_invalid_d;
            sat_cnt_q     <= sat_cnt_d;
        end
    end

    assign io.out         = out_q;
    assign io.out_valid   = out_valid_q;
    assign io.out_invalid = out_invalid_q;
    assign io.ch_ptr      = ch_ptr_q;
    assign sat_cnt        = sat_cnt_q;

endmodule

// File: tb/tb_rx_adc_ti_core.sv
// Bench for rx_adc_ti_core: directed scenarios then random stimulus against a voltage-domain model.
// Latency: model commits a sample one cycle after its sampling edge; outputs compared after each edge.
// Backpressure: none exercised; the DUT never stalls.
module tb_rx_adc_ti_core;
    localparam int  N_CH      = 4;
    localparam int  N_ADC     = 8;
    localparam int  IN_WIDTH  = 18;
    localparam int  DT_WIDTH  = 27;
    localparam int  SAT_CNT_W = 4;
    localparam int  CH_W      = 2;
    localparam int  SAT_MAX   = 15;
    localparam real V_P       = 1.0;
    localparam real V_N       = -1.0;

    logic                     emu_clk = 1'b0;
    logic                     emu_rst_n = 1'b1;
    logic                     cfg_we;
    logic [CH_W-1:0]          cfg_addr;
    logic signed [N_ADC-1:0]  cfg_data;
    logic                     sat_clr;
    logic [DT_WIDTH-1:0]      dt_req_max;
    logic [DT_WIDTH-1:0]      dt_req;
    logic [SAT_CNT_W-1:0]     sat_cnt;
    logic [DT_WIDTH-1:0]      emu_dt;

    rx_adc_ti_core_if #(.N_CH(N_CH), .N_ADC(N_ADC), .IN_WIDTH(IN_WIDTH)) bus ();

    rx_adc_ti_core #(
        .N_CH(N_CH), .N_ADC(N_ADC), .IN_WIDTH(IN_WIDTH), .DT_WIDTH(DT_WIDTH), .SAT_CNT_W(SAT_CNT_W)
    ) dut (
        .emu_clk    (emu_clk),
        .emu_rst_n  (emu_rst_n),
        .io         (bus),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_data   (cfg_data),
        .sat_clr    (sat_clr),
        .dt_req_max (dt_req_max),
        .dt_req     (dt_req),
        .sat_cnt    (sat_cnt),
        .emu_dt     (emu_dt)
    );

    always #5 emu_clk = ~emu_clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Stimulus for the next cycle.
    int d_in, d_addr, d_data;
    bit d_ok, d_clk, d_align, d_we, d_clr;

    // Reference model state.
    int          m_ptr, m_sat;
    bit          m_bad, m_clk_prev, m_ov, m_oi;
    int          m_shadow[N_CH];
    int          m_off[N_CH];
    logic [31:0] m_out;
    bit          p_vld, p_ok, p_sat;
    int          p_ch, p_code;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Ideal converter: volts -> nearest LSB (ties up), plus offset, clipped.
    function automatic void quantise(input int x, input bit ok, input int off,
                                     output int code, output bit sat);
        real volts, lsb;
        int  raw;
        volts = real'(x) / 4096.0;
        lsb   = (V_P - V_N) / 256.0;
        raw   = $rtoi($floor((volts - (V_P + V_N) / 2.0) / lsb + 0.5)) + off;
        code  = raw;
        if (raw > 127)  code = 127;
        if (raw < -128) code = -128;
        sat = (code != raw);
        if (!ok) begin
            code = 0;
            sat  = 1'b0;
        end
    endfunction

    task automatic m_reset();
        m_ptr = 0; m_sat = 0; m_bad = 0; m_clk_prev = 0; m_ov = 0; m_oi = 0;
        m_out = '0; p_vld = 0; p_ok = 0; p_sat = 0; p_ch = 0; p_code = 0;
        for (int k = 0; k < N_CH; k++) begin
            m_shadow[k] = 0;
            m_off[k]    = 0;
        end
    endtask

    // Advance the model by one clock using the stimulus of this cycle.
    task automatic model_cycle();
        bit ev, n_ok, n_sat;
        int n_ch, n_code;
        ev = d_clk && !m_clk_prev;
        n_ch = 0; n_code = 0; n_ok = 0; n_sat = 0;
        if (ev) begin
            n_ch = d_align ? 0 : m_ptr;
            n_ok = d_ok;
            quantise(d_in, d_ok, m_off[n_ch], n_code, n_sat);
        end
        if (d_align) begin
            for (int k = 0; k < N_CH; k++) m_shadow[k] = 0;
            m_bad = 0;
        end
        m_ov = 0;
        if (p_vld) begin
            m_shadow[p_ch] = p_code;
            if (!p_ok) m_bad = 1;
            if (p_ch == N_CH - 1) begin
                for (int k = 0; k < N_CH; k++) m_out[k*N_ADC +: N_ADC] = N_ADC'(m_shadow[k]);
                m_ov = 1;
                m_oi = m_bad;
                m_bad = 0;
            end
        end
        if (d_clr) m_sat = (p_vld && p_sat) ? 1 : 0;
        else if (p_vld && p_sat && m_sat < SAT_MAX) m_sat++;
        if (ev) m_ptr = (n_ch + 1) % N_CH;
        else if (d_align) m_ptr = 0;
        if (d_we) m_off[d_addr] = d_data;
        m_clk_prev = d_clk;
        p_vld = ev; p_ch = n_ch; p_code = n_code; p_ok = n_ok; p_sat = n_sat;
    endtask

    task automatic step();
        @(negedge emu_clk);
        bus.in_      = IN_WIDTH'(d_in);
        bus.in_valid = d_ok;
        bus.clk_val  = d_clk;
        bus.align    = d_align;
        cfg_we       = d_we;
        cfg_addr     = CH_W'(d_addr);
        cfg_data     = N_ADC'(d_data);
        sat_clr      = d_clr;
        dt_req_max   = DT_WIDTH'($urandom);
        emu_dt       = DT_WIDTH'($urandom);
        model_cycle();
        @(posedge emu_clk);
        #1;
        check_eq("out",         bus.out,         m_out);
        check_eq("out_valid",   bus.out_valid,   m_ov);
        check_eq("out_invalid", bus.out_invalid, m_oi);
        check_eq("ch_ptr",      bus.ch_ptr,      m_ptr);
        check_eq("sat_cnt",     sat_cnt,         m_sat);
        check_eq("dt_req",      dt_req,          dt_req_max);
        d_align = 0; d_we = 0; d_clr = 0;
    endtask

    // One sampling edge followed by the mandatory low cycle (the commit cycle).
    task automatic sample(input int x, input bit ok, input bit clr_at_commit);
        d_in = x; d_ok = ok; d_clk = 1;
        step();
        d_clk = 0; d_clr = clr_at_commit;
        step();
    endtask

    task automatic check_zero_outputs(input string tag);
        check_eq({tag, "_out"},     bus.out,         0);
        check_eq({tag, "_vld"},     bus.out_valid,   0);
        check_eq({tag, "_invalid"}, bus.out_invalid, 0);
        check_eq({tag, "_ptr"},     bus.ch_ptr,      0);
        check_eq({tag, "_sat"},     sat_cnt,         0);
    endtask

    initial begin
        d_in = 0; d_ok = 1; d_clk = 0; d_align = 0; d_we = 0; d_addr = 0; d_data = 0; d_clr = 0;
        bus.in_ = '0; bus.in_valid = 1'b0; bus.clk_val = 1'b0; bus.align = 1'b0;
        cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0; sat_clr = 1'b0; dt_req_max = '0; emu_dt = '0;
        m_reset();
        #1 emu_rst_n = 1'b0;
        repeat (2) @(posedge emu_clk);
        #1;
        check_zero_outputs("reset");
        @(negedge emu_clk) emu_rst_n = 1'b1;

        // +0.5 V on every channel -> 64 each.
        for (int i = 0; i < 4; i++) sample(2048, 1, 0);
        check_eq("ramp_vld",  bus.out_valid, 1);
        check_eq("ramp_out",  bus.out, 32'h40404040);
        check_eq("ramp_inv",  bus.out_invalid, 0);

        // Overrange both ways, then counter hold and clear-with-clip.
        for (int i = 0; i < 4; i++) sample((i % 2 == 0) ? 6144 : -6144, 1, 0);
        check_eq("ovr_out", bus.out, 32'h807f807f);
        check_eq("ovr_sat4", sat_cnt, 4);
        for (int i = 0; i < 16; i++) sample(6144, 1, 0);
        check_eq("ovr_sat_hold", sat_cnt, SAT_MAX);
        sample(6144, 1, 1);
        check_eq("ovr_sat_clr", sat_cnt, 1);
        d_align = 1; step();
        check_eq("align_ptr", bus.ch_ptr, 0);

        // Offset write coincident with channel 2's sample takes effect from the next frame.
        sample(0, 1, 0);
        sample(0, 1, 0);
        d_we = 1; d_addr = 2; d_data = 5;
        sample(0, 1, 0);
        sample(0, 1, 0);
        check_eq("ofs_same_cycle", bus.out, 32'h0);
        for (int i = 0; i < 4; i++) sample(0, 1, 0);
        check_eq("ofs_applied", bus.out, 32'h00050000);

        // Two samples, then realign: those samples must never be published.
        sample(2048, 1, 0);
        sample(2048, 1, 0);
        d_align = 1; step();
        for (int i = 0; i < 3; i++) sample(-1024, 1, 0);
        check_eq("mis_no_early", bus.out, 32'h00050000);
        sample(-1024, 1, 0);
        check_eq("mis_out", bus.out, 32'he0e5e0e0);

        // Invalid sample on channel 1 flags only its own frame.
        for (int i = 0; i < 4; i++) sample(2048, i != 1, 0);
        check_eq("inv_out",  bus.out, 32'h40450040);
        check_eq("inv_flag", bus.out_invalid, 1);
        for (int i = 0; i < 4; i++) sample(2048, 1, 0);
        check_eq("inv_clear", bus.out_invalid, 0);

        // Align together with a sampling edge.
        sample(2048, 1, 0);
        d_align = 1;
        sample(2048, 1, 0);
        check_eq("align_evt_ptr", bus.ch_ptr, 1);

        // Asynchronous reset in the middle of a frame.
        sample(6144, 1, 0);
        sample(6144, 1, 0);
        #3 emu_rst_n = 1'b0;
        #1;
        check_zero_outputs("midrst");
        m_reset();
        d_clk = 0;
        bus.clk_val = 1'b0;
        @(negedge emu_clk) emu_rst_n = 1'b1;
        sample(-1024, 1, 0);
        check_eq("post_rst_ptr", bus.ch_ptr, 1);
        for (int i = 0; i < 3; i++) sample(2048, 1, 0);
        check_eq("post_rst_out", bus.out, 32'h404040e0);

        // Random traffic with random control pulses.
        for (int i = 0; i < 1500; i++) begin
            d_clk = $urandom_range(0, 1) == 1;
            if ($urandom_range(0, 3) == 0) d_in = int'($urandom_range(0, 262143)) - 131072;
            else                           d_in = int'($urandom_range(0, 16383)) - 8192;
            d_ok = $urandom_range(0, 9) != 0;
            if (!d_ok) d_in = int'($urandom_range(0, 6000)) - 3000;
            d_align = $urandom_range(0, 29) == 0;
            d_we    = $urandom_range(0, 19) == 0;
            d_addr  = int'($urandom_range(0, N_CH - 1));
            d_data  = int'($urandom_range(0, 40)) - 20;
            d_clr   = $urandom_range(0, 24) == 0;
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
